// File: rtl/cache_axi_pkg.sv
// Shared encodings for the cache-to-AXI read arbiter: FSM states, read types,
// transaction IDs and AXI burst/response codes.
package cache_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_t;

    localparam logic [2:0] RT_BYTE = 3'd0;
    localparam logic [2:0] RT_HALF = 3'd1;
    localparam logic [2:0] RT_WORD = 3'd2;
    localparam logic [2:0] RT_LINE = 3'd4;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/arb2_rr.sv
// Two-way icache/dcache grant. CACHE_ARB_RR_EN selects round-robin; otherwise
// dcache always wins a tie and no pointer state exists.
module arb2_rr (
`ifdef CACHE_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic grant_d
);

`ifdef CACHE_ARB_RR_EN
    // Pointer records the last winner; reset value "icache" hands the first tie to dcache.
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst)
            last_d <= 1'b0;
        else if (take)
            last_d <= grant_d;
    end

    always_comb begin
        grant_d = req_d;
        if (req_i && req_d)
            grant_d = !last_d;
    end
`else
    always_comb begin
        grant_d = req_d;
    end
`endif

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Arbitrates icache/dcache reads onto one AXI read channel, one transaction at a time.
// Arbitration policy follows macro CACHE_ARB_RR_EN (round-robin) or fixed dcache priority.
module cache_axi_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_r_req,
    input  logic [ADDR_W-1:0] i_r_addr,
    input  logic [2:0]        i_r_type,
    output logic              i_r_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_r_data,
    input  logic              d_r_req,
    input  logic [ADDR_W-1:0] d_r_addr,
    input  logic [2:0]        d_r_type,
    output logic              d_r_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_r_data,
    output logic              d_ret_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    arb_state_t        state, state_nx;
    logic              owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [7:0]        beat_cnt;
    logic              grant_d;
    logic              take;
    logic              is_line;
    logic              beat;

    assign take = (state == ST_IDLE) && (i_r_req || d_r_req);

    arb2_rr u_arb (
`ifdef CACHE_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .req_i   (i_r_req),
        .req_d   (d_r_req),
        .take    (take),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
        end else if (take) begin
            owner_d <= grant_d;
            addr_q  <= grant_d ? d_r_addr : i_r_addr;
            type_q  <= grant_d ? d_r_type : i_r_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_DATA)
            beat_cnt <= '0;
        else if (rvalid)
            beat_cnt <= beat_cnt + 8'd1;
    end

    always_comb begin
        state_nx = state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        i_r_rdy  = 1'b0;
        d_r_rdy  = 1'b0;
        case (state)
            ST_IDLE: if (take) state_nx = ST_ADDR;
            ST_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    i_r_rdy  = !owner_d;
                    d_r_rdy  = owner_d;
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // AR fields derive from the latched request so they hold steady while arready stalls.
    always_comb begin
        is_line = (type_q == RT_LINE);
        araddr  = is_line ? {addr_q[ADDR_W-1:6], 6'b0} : addr_q;
        arlen   = is_line ? 8'(LINE_BEATS - 1) : 8'd0;
        arsize  = is_line ? 3'd2 : {1'b0, type_q[1:0]};
        arburst = BURST_INCR;
        arid    = owner_d ? ID_DCACHE : ID_ICACHE;
    end

    always_comb begin
        beat        = (state == ST_DATA) && rvalid;
        i_ret_valid = beat && !owner_d;
        d_ret_valid = beat && owner_d;
        i_ret_last  = i_ret_valid && rlast;
        d_ret_last  = d_ret_valid && rlast;
        d_ret_err   = d_ret_valid && (rresp != RESP_OKAY);
        i_r_data    = rdata;
        d_r_data    = rdata;
    end

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state == ST_ADDR) |-> (owner_d ? d_r_req : i_r_req));
    a_rid_match: assert property (@(posedge clk) disable iff (rst)
        (state == ST_DATA && rvalid) |-> (rid == arid));
    a_beat_count: assert property (@(posedge clk) disable iff (rst)
        (state == ST_DATA && rvalid && rlast) |-> (beat_cnt == arlen));

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Scoreboard bench for cache_axi_rd_arbiter: driver pushes expected AR/beat
// records, a negedge monitor pops and compares when the DUT presents them.
module tb_cache_axi_rd_arbiter;

    logic        clk, rst;
    logic        i_r_req, d_r_req;
    logic [31:0] i_r_addr, d_r_addr;
    logic [2:0]  i_r_type, d_r_type;
    logic        i_r_rdy, i_ret_valid, i_ret_last;
    logic        d_r_rdy, d_ret_valid, d_ret_last, d_ret_err;
    logic [31:0] i_r_data, d_r_data;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    cache_axi_rd_arbiter #(.ADDR_W(32), .LINE_BEATS(16)) dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_type(i_r_type), .i_r_rdy(i_r_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_r_data(i_r_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_type(d_r_type), .d_r_rdy(d_r_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_r_data(d_r_data),
        .d_ret_err(d_ret_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic        d;
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    ar_t   ar_q[$];
    beat_t beat_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_sim;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic outs_zero(input string name);
        chk(name, {arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid,
                   i_ret_last, d_ret_last, d_ret_err, arid, araddr, arlen, arsize}, 64'd0);
    endtask

    // Monitor: AR handshakes, AR stall stability and returned beats.
    ar_t   cur_ar, exp_ar, prev_ar;
    beat_t exp_b;
    logic  prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_ar = {arid, araddr, arlen, arsize};
            if (prev_stall) begin
                chk("ar_hold_valid", arvalid, 1);
                chk("ar_hold_fields", cur_ar, prev_ar);
            end
            if (i_r_rdy || d_r_rdy)
                chk("rdy_without_handshake", arvalid && arready, 1);
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    chk("unexpected_ar", 1, 0);
                end else begin
                    exp_ar = ar_q.pop_front();
                    chk("ar_fields", cur_ar, exp_ar);
                    chk("arburst", arburst, 2'b01);
                    chk("i_r_rdy", i_r_rdy, exp_ar.id == 4'd0);
                    chk("d_r_rdy", d_r_rdy, exp_ar.id == 4'd1);
                end
            end
            if (i_ret_last && !i_ret_valid) chk("i_last_without_valid", 1, 0);
            if (i_ret_valid || d_ret_valid) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    exp_b = beat_q.pop_front();
                    chk("ret_route", {i_ret_valid, d_ret_valid}, exp_b.d ? 2'b01 : 2'b10);
                    chk("ret_data", exp_b.d ? d_r_data : i_r_data, exp_b.data);
                    chk("ret_last", {i_ret_last, d_ret_last},
                        exp_b.last ? (exp_b.d ? 2'b01 : 2'b10) : 2'b00);
                    chk("d_ret_err", d_ret_err, exp_b.err);
                end
            end
            prev_stall = arvalid && !arready;
            prev_ar    = cur_ar;
        end
    end

    task automatic push_ar(input bit d, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz);
        ar_t e;
        e = {d ? 4'd1 : 4'd0, a, len, sz};
        ar_q.push_back(e);
    endtask

    // Waits for the AR handshake, holding arready low for ar_delay stalled cycles.
    task automatic ar_phase(input int ar_delay, input bit exp_d);
        int n = 0;
        int stalled = 0;
        bit done = 0;
        arready = (ar_delay == 0);
        while (!done) begin
            @(negedge clk);
            if (arvalid && arready) done = 1;
            else if (arvalid) stalled++;
            n++;
            if (!done && n > 40) begin
                chk("ar_timeout", 0, 1);
                finish_sim();
            end
            @(posedge clk); #1;
            if (!done && stalled >= ar_delay) arready = 1'b1;
        end
        arready = 1'b0;
        if (exp_d) d_r_req = 1'b0;
        else       i_r_req = 1'b0;
    endtask

    task automatic data_phase(input bit d, input int n, input logic [31:0] base,
                              input int err_beat, input int abort_after);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            if (abort_after > 0 && k == abort_after) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                outs_zero("reset_mid_burst");
                return;
            end
            rvalid = 1'b1;
            rid    = d ? 4'd1 : 4'd0;
            rdata  = base + 32'(k);
            rlast  = (k == n - 1);
            rresp  = (k == err_beat) ? 2'd2 : 2'd0;
            b = {d, base + 32'(k), k == n - 1, d && (k == err_beat)};
            beat_q.push_back(b);
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        @(negedge clk);
        chk("idle_after_last", {arvalid, rready}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef CACHE_ARB_RR_EN
    bit win[3] = '{1'b1, 1'b0, 1'b1};
`else
    bit win[3] = '{1'b1, 1'b1, 1'b1};
`endif

    initial begin
        rst = 1'b1;
        i_r_req = 0; i_r_addr = '0; i_r_type = '0;
        d_r_req = 0; d_r_addr = '0; d_r_type = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        // icache line fill, critical-word address aligned down to 64 B
        i_r_req = 1; i_r_addr = 32'h1000_0044; i_r_type = 3'd4;
        push_ar(0, 32'h1000_0040, 8'd15, 3'd2);
        ar_phase(0, 0);
        data_phase(0, 16, 32'hA000_0000, -1, 0);

        // dcache halfword, raw address
        d_r_req = 1; d_r_addr = 32'h2000_0003; d_r_type = 3'd1;
        push_ar(1, 32'h2000_0003, 8'd0, 3'd1);
        ar_phase(0, 1);
        data_phase(1, 1, 32'hB000_0000, -1, 0);

        // icache byte read
        i_r_req = 1; i_r_addr = 32'h8000_0005; i_r_type = 3'd0;
        push_ar(0, 32'h8000_0005, 8'd0, 3'd0);
        ar_phase(0, 0);
        data_phase(0, 1, 32'hC000_0000, -1, 0);

        // arready stalled 5 cycles
        d_r_req = 1; d_r_addr = 32'h3000_0008; d_r_type = 3'd2;
        push_ar(1, 32'h3000_0008, 8'd0, 3'd2);
        ar_phase(5, 1);
        data_phase(1, 1, 32'hD000_0000, -1, 0);

        // dcache line with an error response on beat 3 only
        d_r_req = 1; d_r_addr = 32'h4000_0010; d_r_type = 3'd4;
        push_ar(1, 32'h4000_0000, 8'd15, 3'd2);
        ar_phase(0, 1);
        data_phase(1, 16, 32'hE000_0000, 3, 0);

        // reset after 7 beats of an icache line, then a normal read
        i_r_req = 1; i_r_addr = 32'h7000_0084; i_r_type = 3'd4;
        push_ar(0, 32'h7000_0080, 8'd15, 3'd2);
        ar_phase(0, 0);
        data_phase(0, 16, 32'h1100_0000, -1, 7);
        @(posedge clk); #1;
        i_r_req = 1; i_r_addr = 32'h7000_0100; i_r_type = 3'd2;
        push_ar(0, 32'h7000_0100, 8'd0, 3'd2);
        ar_phase(0, 0);
        data_phase(0, 1, 32'h2200_0000, -1, 0);

        // three simultaneous-request rounds from a fresh pointer, then the leftover icache
        apply_reset();
        i_r_req = 1; i_r_addr = 32'h5000_0000; i_r_type = 3'd2;
        d_r_req = 1; d_r_addr = 32'h6000_0000; d_r_type = 3'd2;
        for (int r = 0; r < 3; r++) begin
            push_ar(win[r], win[r] ? 32'h6000_0000 : 32'h5000_0000, 8'd0, 3'd2);
            ar_phase(0, win[r]);
            if (r < 2) begin
                if (win[r]) d_r_req = 1'b1;
                else        i_r_req = 1'b1;
            end
            data_phase(win[r], 1, 32'h3300_0000 + 32'(r), -1, 0);
        end
        push_ar(0, 32'h5000_0000, 8'd0, 3'd2);
        ar_phase(0, 0);
        data_phase(0, 1, 32'h4400_0000, -1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ar_queue_drained", 32'(ar_q.size()), 0);
        chk("beat_queue_drained", 32'(beat_q.size()), 0);
        finish_sim();
    end

    initial begin
        #200000;
        chk("watchdog", 0, 1);
        finish_sim();
    end

endmodule
